vga_sync_decoder: RTL

Receive-side counterpart of the VGA timing generator. Samples an hsync/vsync/video_on stream (active-low sync pulses, 25 MHz pixel clock, same clock domain) and recovers per-pixel coordinates. Measures line period and lines per frame, and declares lock after two consistent frames. Used for generator loopback checks and as the front end of a pixel-capture path.

---
 rtl/vga_sync_decoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a VGA hsync/vsync/video_on stream in the pixel clock domain.
// Measures line period and lines per frame, and declares lock after two consistent frames.
module vga_sync_decoder #(
  parameter int unsigned W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         hsync,
  input  logic         vsync,
  input  logic         video_on,
  output logic         pixel_valid,
  output logic [W-1:0] pixelX,
  output logic [W-1:0] pixelY,
  output logic         frame_start,
  output logic         locked,
  output logic         timing_error,
  output logic [W-1:0] line_period,
  output logic [W-1:0] frame_lines
);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  state_t       state_q, state_d;
  logic         h_q, v_q, a_q;
  logic [W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [W-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic [W-1:0] line_ref_q, line_ref_d;
  logic         ref_valid_q, ref_valid_d;
  logic [W-1:0] line_period_q, line_period_d, frame_lines_q, frame_lines_d;
  logic         pixel_valid_q, frame_start_q, locked_q, timing_error_q;
  logic         locked_d, timing_error_d;
  logic         hfall, vfall, afall, arise, err;

  always_comb begin
    hfall = h_q & ~hsync;
    vfall = v_q & ~vsync;
    afall = a_q & ~video_on;
    arise = ~a_q & video_on;

    if (hfall)                hcount_d = ONE;
    else if (hcount_q != MAX) hcount_d = hcount_q + ONE;
    else                      hcount_d = hcount_q;

    // A line starting on the same edge as vsync falls belongs to the new frame.
    vcount_d = vcount_q;
    if (vfall)                          vcount_d = hfall ? ONE : '0;
    else if (hfall && vcount_q != MAX)  vcount_d = vcount_q + ONE;

    pixel_x_d = pixel_x_q;
    if (arise)                               pixel_x_d = '0;
    else if (video_on && pixel_x_q != MAX)   pixel_x_d = pixel_x_q + ONE;

    pixel_y_d = pixel_y_q;
    if (vfall)                               pixel_y_d = '0;
    else if (afall && pixel_y_q != MAX)      pixel_y_d = pixel_y_q + ONE;

    state_d       = state_q;
    line_ref_d    = line_ref_q;
    ref_valid_d   = ref_valid_q;
    line_period_d = line_period_q;
    frame_lines_d = frame_lines_q;
    err           = 1'b0;

    case (state_q)
      SEARCH: begin
        if (vfall) begin
          state_d     = MEASURE;
          ref_valid_d = 1'b0;
        end
      end
      MEASURE: begin
        if (hfall) begin
          if (!ref_valid_q) begin
            line_ref_d  = hcount_q;
            ref_valid_d = 1'b1;
          end else if (hcount_q != line_ref_q) begin
            err = 1'b1;
          end
        end
        if (vfall) begin
          frame_lines_d = vcount_q;
          line_period_d = line_ref_d;
          state_d       = VERIFY;
        end
      end
      default: begin
        if (hfall && hcount_q != line_period_q) err = 1'b1;
        if (vfall) begin
          if (vcount_q == frame_lines_q) state_d = LOCKED;
          else                           err = 1'b1;
        end
      end
    endcase

    if (state_q != SEARCH && (hcount_q == MAX || vcount_q == MAX)) err = 1'b1;

    // Measured values only advance on a clean MEASURE->VERIFY hand-off.
    if (err) begin
      state_d       = SEARCH;
      line_period_d = line_period_q;
      frame_lines_d = frame_lines_q;
    end

    timing_error_d = err;
    locked_d       = (state_d == LOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= SEARCH;
      h_q            <= 1'b1;
      v_q            <= 1'b1;
      a_q            <= 1'b0;
      hcount_q       <= '0;
      vcount_q       <= '0;
      pixel_x_q      <= '0;
      pixel_y_q      <= '0;
      line_ref_q     <= '0;
      ref_valid_q    <= 1'b0;
      line_period_q  <= '0;
      frame_lines_q  <= '0;
      pixel_valid_q  <= 1'b0;
      frame_start_q  <= 1'b0;
      locked_q       <= 1'b0;
      timing_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      h_q            <= hsync;
      v_q            <= vsync;
      a_q            <= video_on;
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      pixel_x_q      <= pixel_x_d;
      pixel_y_q      <= pixel_y_d;
      line_ref_q     <= line_ref_d;
      ref_valid_q    <= ref_valid_d;
      line_period_q  <= line_period_d;
      frame_lines_q  <= frame_lines_d;
      pixel_valid_q  <= video_on;
      frame_start_q  <= vfall;
      locked_q       <= locked_d;
      timing_error_q <= timing_error_d;
    end
  end

  assign pixel_valid  = pixel_valid_q;
  assign pixelX       = pixel_x_q;
  assign pixelY       = pixel_y_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign timing_error = timing_error_q;
  assign line_period  = line_period_q;
  assign frame_lines  = frame_lines_q;

endmodule
